lcd_power_seq: RTL and testbench



---
 rtl/lcd_seq_pkg.sv | 86 ++++++++
 rtl/lcd_power_seq_if.sv | 29 ++
 rtl/tick_gen.sv | 31 +++
 rtl/lcd_power_seq.sv | 155 +++++++++++++++
 tb/tb_lcd_power_seq.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/lcd_seq_pkg.sv
// Shared definitions for the TFT panel power sequencer: state encoding,
// enable-set decoding and the default delay constants.
package lcd_seq_pkg;

   // Default timing: 1 ms ticks at 100 MHz, step delays in ticks.
   localparam int unsigned DEF_PRESCALE = 100000;
   localparam int unsigned DEF_T_PWR    = 20;
   localparam int unsigned DEF_T_DE     = 10;
   localparam int unsigned DEF_T_DISP   = 10;
   localparam int unsigned DEF_T_RGB    = 200;

   localparam int unsigned TICK_CNT_W   = 16;

   // Sequencer states; the debug port exposes this encoding directly.
   typedef enum logic [3:0] {
      ST_OFF     = 4'd0,
      ST_UP_PWR  = 4'd1,
      ST_UP_DE   = 4'd2,
      ST_UP_DISP = 4'd3,
      ST_UP_RGB  = 4'd4,
      ST_ON      = 4'd5,
      ST_DN_RGB  = 4'd6,
      ST_DN_DISP = 4'd7,
      ST_DN_DE   = 4'd8,
      ST_DN_PWR  = 4'd9
   } state_t;

   // Panel enable set, in power-up order.
   typedef struct packed {
      logic tft;
      logic de;
      logic disp;
      logic rgb;
      logic led;
   } enables_t;

   // Enable set held in each state. Each DN state mirrors the UP state
   // with the same rails, which is what makes an abort glitch-free.
   function automatic enables_t state_enables(input state_t st);
      enables_t en;
      en = '0;
      case (st)
         ST_UP_PWR, ST_DN_PWR: begin
            en.tft = 1'b1;
         end
         ST_UP_DE, ST_DN_DE: begin
            en.tft = 1'b1;
            en.de  = 1'b1;
         end
         ST_UP_DISP, ST_DN_DISP: begin
            en.tft  = 1'b1;
            en.de   = 1'b1;
            en.disp = 1'b1;
         end
         ST_UP_RGB, ST_DN_RGB: begin
            en.tft  = 1'b1;
            en.de   = 1'b1;
            en.disp = 1'b1;
            en.rgb  = 1'b1;
         end
         ST_ON: begin
            en.tft  = 1'b1;
            en.de   = 1'b1;
            en.disp = 1'b1;
            en.rgb  = 1'b1;
            en.led  = 1'b1;
         end
         default: begin
            en = '0;
         end
      endcase
      return en;
   endfunction

   // True for every transitional (UP_x / DN_x) state.
   function automatic logic state_busy(input state_t st);
      logic b;
      case (st)
         ST_UP_PWR, ST_UP_DE, ST_UP_DISP, ST_UP_RGB,
         ST_DN_RGB, ST_DN_DISP, ST_DN_DE, ST_DN_PWR: b = 1'b1;
         default:                                    b = 1'b0;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/lcd_power_seq_if.sv
// Request/status bundle between board control logic and the panel
// power sequencer.
interface lcd_power_seq_if;
   import lcd_seq_pkg::*;

   logic   start;
   logic   stop;
   logic   TFT_en;
   logic   de_en;
   logic   disp_en;
   logic   rgb_en;
   logic   led_en;
   logic   ready;
   logic   busy;
   state_t state;

   // Board-side controller issuing requests.
   modport master (
      output start, stop,
      input  TFT_en, de_en, disp_en, rgb_en, led_en, ready, busy, state
   );

   // Sequencer side.
   modport slave (
      input  start, stop,
      output TFT_en, de_en, disp_en, rgb_en, led_en, ready, busy, state
   );

endinterface

// File: rtl/tick_gen.sv
// Delay-tick prescaler: divides the system clock by PRESCALE and emits a
// one-cycle tick on the last count. A synchronous clear restarts the
// division so every step dwell starts from a fresh prescaler phase.
module tick_gen #(
   parameter int unsigned PRESCALE = 4
) (
   input  logic Clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int unsigned   PW     = $clog2(PRESCALE);
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] presc_r;

   // Prescaler count, wrapping at PRESCALE-1 and cleared on request.
   always_ff @(posedge Clk) begin
      if (rst || clr) begin
         presc_r <= '0;
      end else if (presc_r == P_LAST) begin
         presc_r <= '0;
      end else begin
         presc_r <= presc_r + PW'(1);
      end
   end

   assign tick = (presc_r == P_LAST);

endmodule

// File: rtl/lcd_power_seq.sv
// Request-driven power sequencer for the 480x272 TFT panel. Brings the
// panel rails up in order (supply, DE gate, DISP, RGB, backlight) with
// programmable inter-step delays and tears them down in reverse.
module lcd_power_seq
   import lcd_seq_pkg::*;
#(
   parameter int unsigned PRESCALE = DEF_PRESCALE,
   parameter int unsigned T_PWR    = DEF_T_PWR,
   parameter int unsigned T_DE     = DEF_T_DE,
   parameter int unsigned T_DISP   = DEF_T_DISP,
   parameter int unsigned T_RGB    = DEF_T_RGB
) (
   input  logic        Clk,
   input  logic        rst,
   lcd_power_seq_if.slave bus
);

   // Last tick index of each step; the step ends on the tick that brings
   // the count to T-1.
   localparam logic [TICK_CNT_W-1:0] T_PWR_LAST  = TICK_CNT_W'(T_PWR - 1);
   localparam logic [TICK_CNT_W-1:0] T_DE_LAST   = TICK_CNT_W'(T_DE - 1);
   localparam logic [TICK_CNT_W-1:0] T_DISP_LAST = TICK_CNT_W'(T_DISP - 1);
   localparam logic [TICK_CNT_W-1:0] T_RGB_LAST  = TICK_CNT_W'(T_RGB - 1);

   state_t                  state_r;
   state_t                  next_state_s;
   enables_t                en_r;
   logic                    ready_r;
   logic                    busy_r;
   logic [TICK_CNT_W-1:0]   tick_cnt_r;
   logic [TICK_CNT_W-1:0]   step_last_s;
   logic                    tick_s;
   logic                    step_done_s;
   logic                    state_change_s;

   assign state_change_s = (next_state_s != state_r);

   tick_gen #(
      .PRESCALE (PRESCALE)
   ) u_tick_gen (
      .Clk  (Clk),
      .rst  (rst),
      .clr  (state_change_s),
      .tick (tick_s)
   );

   // Select the delay of the current step; mirrored DN steps share the
   // value of their UP counterpart.
   always_comb begin
      step_last_s = '0;
      case (state_r)
         ST_UP_PWR,  ST_DN_PWR:  step_last_s = T_PWR_LAST;
         ST_UP_DE,   ST_DN_DE:   step_last_s = T_DE_LAST;
         ST_UP_DISP, ST_DN_DISP: step_last_s = T_DISP_LAST;
         ST_UP_RGB,  ST_DN_RGB:  step_last_s = T_RGB_LAST;
         default:                step_last_s = '0;
      endcase
   end

   assign step_done_s = tick_s && (tick_cnt_r == step_last_s);

   // Tick counter: restarts on every state change, only counts while a
   // step is in progress so it never wraps while parked in OFF or ON.
   always_ff @(posedge Clk) begin
      if (rst || state_change_s) begin
         tick_cnt_r <= '0;
      end else if (busy_r && tick_s) begin
         tick_cnt_r <= tick_cnt_r + TICK_CNT_W'(1);
      end else begin
         tick_cnt_r <= tick_cnt_r;
      end
   end

   // Next-state logic: stop aborts an UP step into the DN step holding
   // the same rails; DN steps always run through to OFF.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_OFF: begin
            if (bus.start && !bus.stop) next_state_s = ST_UP_PWR;
            else                        next_state_s = ST_OFF;
         end
         ST_UP_PWR: begin
            if (bus.stop)         next_state_s = ST_DN_PWR;
            else if (step_done_s) next_state_s = ST_UP_DE;
            else                  next_state_s = ST_UP_PWR;
         end
         ST_UP_DE: begin
            if (bus.stop)         next_state_s = ST_DN_DE;
            else if (step_done_s) next_state_s = ST_UP_DISP;
            else                  next_state_s = ST_UP_DE;
         end
         ST_UP_DISP: begin
            if (bus.stop)         next_state_s = ST_DN_DISP;
            else if (step_done_s) next_state_s = ST_UP_RGB;
            else                  next_state_s = ST_UP_DISP;
         end
         ST_UP_RGB: begin
            if (bus.stop)         next_state_s = ST_DN_RGB;
            else if (step_done_s) next_state_s = ST_ON;
            else                  next_state_s = ST_UP_RGB;
         end
         ST_ON: begin
            if (bus.stop) next_state_s = ST_DN_RGB;
            else          next_state_s = ST_ON;
         end
         ST_DN_RGB: begin
            if (step_done_s) next_state_s = ST_DN_DISP;
            else             next_state_s = ST_DN_RGB;
         end
         ST_DN_DISP: begin
            if (step_done_s) next_state_s = ST_DN_DE;
            else             next_state_s = ST_DN_DISP;
         end
         ST_DN_DE: begin
            if (step_done_s) next_state_s = ST_DN_PWR;
            else             next_state_s = ST_DN_DE;
         end
         ST_DN_PWR: begin
            if (step_done_s) next_state_s = ST_OFF;
            else             next_state_s = ST_DN_PWR;
         end
         default: begin
            next_state_s = ST_OFF;
         end
      endcase
   end

   // State and status registers. Outputs are decoded from the next state
   // and registered alongside it, so they always match the state register
   // and carry no combinational path from the request inputs.
   always_ff @(posedge Clk) begin
      if (rst) begin
         state_r <= ST_OFF;
         en_r    <= '0;
         ready_r <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= next_state_s;
         en_r    <= state_enables(next_state_s);
         ready_r <= (next_state_s == ST_ON);
         busy_r  <= state_busy(next_state_s);
      end
   end

   assign bus.TFT_en  = en_r.tft;
   assign bus.de_en   = en_r.de;
   assign bus.disp_en = en_r.disp;
   assign bus.rgb_en  = en_r.rgb;
   assign bus.led_en  = en_r.led;
   assign bus.ready   = ready_r;
   assign bus.busy    = busy_r;
   assign bus.state   = state_r;

endmodule

// File: tb/tb_lcd_power_seq.sv
// Directed bench for the panel power sequencer with PRESCALE=4 and all
// step delays 2 ticks, so every step dwells 8 cycles.
module tb_lcd_power_seq;
   import lcd_seq_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   lcd_power_seq_if bus ();

   lcd_power_seq #(
      .PRESCALE (4),
      .T_PWR    (2),
      .T_DE     (2),
      .T_DISP   (2),
      .T_RGB    (2)
   ) dut (
      .Clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Observed outputs: {TFT, de, disp, rgb, led, ready, busy}.
   logic [6:0] obs;
   assign obs = {bus.TFT_en, bus.de_en, bus.disp_en, bus.rgb_en,
                 bus.led_en, bus.ready, bus.busy};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one clock and settle just past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      n_checks++;
      if ({obs, bus.state} !== {7'b0000000, ST_OFF}) begin
         n_fail++;
         $display("FAIL reset_init: outs=%b state=%0d, expected outs=0000000 state=0", obs, bus.state);
      end
      rst = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      rst = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         n_checks++;
         if ({obs, bus.state} !== {7'b0000000, ST_OFF}) begin
            n_fail++;
            $display("FAIL reset_hold cycle %0d: outs=%b state=%0d, expected outs=0000000 state=0", i, obs, bus.state);
         end
      end
      rst = 1'b0;
      step();
      n_checks++;
      if ({obs, bus.state} !== {7'b0000000, ST_OFF}) begin
         n_fail++;
         $display("FAIL reset_release: outs=%b state=%0d, expected outs=0000000 state=0", obs, bus.state);
      end
   endtask

   // Starts from OFF, ends in ON.
   task automatic test_power_up();
      state_t     up_tab [4];
      logic [6:0] e;
      state_t     es;
      up_tab = '{ST_UP_PWR, ST_UP_DE, ST_UP_DISP, ST_UP_RGB};
      bus.start = 1'b1;
      for (int c = 1; c <= 33; c++) begin
         step();
         if (c == 1) bus.start = 1'b0;
         e  = {1'(c >= 1), 1'(c >= 9), 1'(c >= 17), 1'(c >= 25),
               1'(c >= 33), 1'(c >= 33), 1'(c <= 32)};
         es = (c <= 32) ? up_tab[(c - 1) / 8] : ST_ON;
         n_checks++;
         if ({obs, bus.state} !== {e, es}) begin
            n_fail++;
            $display("FAIL power_up cycle %0d: outs=%b state=%0d, expected outs=%b state=%0d", c, obs, bus.state, e, es);
         end
      end
   endtask

   task automatic test_start_in_on();
      bus.start = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         step();
         n_checks++;
         if ({obs, bus.state} !== {7'b1111110, ST_ON}) begin
            n_fail++;
            $display("FAIL start_in_on cycle %0d: outs=%b state=%0d, expected outs=1111110 state=5", c, obs, bus.state);
         end
      end
      bus.start = 1'b0;
   endtask

   // Starts from ON, ends in OFF; optionally pulses start in DN_DISP.
   task automatic test_power_down(input bit with_start);
      state_t     dn_tab [4];
      logic [6:0] e;
      state_t     es;
      dn_tab = '{ST_DN_RGB, ST_DN_DISP, ST_DN_DE, ST_DN_PWR};
      bus.stop = 1'b1;
      for (int c = 1; c <= 33; c++) begin
         step();
         if (c == 1) bus.stop = 1'b0;
         e  = {1'(c < 33), 1'(c < 25), 1'(c < 17), 1'(c < 9),
               1'b0, 1'b0, 1'(c <= 32)};
         es = (c <= 32) ? dn_tab[(c - 1) / 8] : ST_OFF;
         n_checks++;
         if ({obs, bus.state} !== {e, es}) begin
            n_fail++;
            $display("FAIL power_down(start=%0d) cycle %0d: outs=%b state=%0d, expected outs=%b state=%0d", with_start, c, obs, bus.state, e, es);
         end
         if (with_start && c == 10) bus.start = 1'b1;
         if (c == 11) bus.start = 1'b0;
      end
      step();
      n_checks++;
      if ({obs, bus.state} !== {7'b0000000, ST_OFF}) begin
         n_fail++;
         $display("FAIL power_down_settle: outs=%b state=%0d, expected outs=0000000 state=0", obs, bus.state);
      end
   endtask

   task automatic test_simultaneous();
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         step();
         n_checks++;
         if ({obs, bus.state} !== {7'b0000000, ST_OFF}) begin
            n_fail++;
            $display("FAIL start_and_stop cycle %0d: outs=%b state=%0d, expected outs=0000000 state=0", c, obs, bus.state);
         end
      end
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      step();
   endtask

   // stop sampled in UP_DE after 12 cycles: DN_DE, DN_PWR, OFF.
   task automatic test_abort();
      logic [6:0] e;
      state_t     es;
      bus.start = 1'b1;
      for (int c = 1; c <= 32; c++) begin
         step();
         if (c == 1) bus.start = 1'b0;
         e  = {1'(c < 29), 1'(c >= 9 && c < 21), 1'b0, 1'b0,
               1'b0, 1'b0, 1'(c <= 28)};
         if (c <= 8)       es = ST_UP_PWR;
         else if (c <= 12) es = ST_UP_DE;
         else if (c <= 20) es = ST_DN_DE;
         else if (c <= 28) es = ST_DN_PWR;
         else              es = ST_OFF;
         n_checks++;
         if ({obs, bus.state} !== {e, es}) begin
            n_fail++;
            $display("FAIL abort cycle %0d: outs=%b state=%0d, expected outs=%b state=%0d", c, obs, bus.state, e, es);
         end
         if (c == 12) bus.stop = 1'b1;
         if (c == 13) bus.stop = 1'b0;
      end
   endtask

   task automatic test_mid_reset();
      bus.start = 1'b1;
      for (int c = 1; c <= 27; c++) begin
         step();
         if (c == 1) bus.start = 1'b0;
      end
      n_checks++;
      if ({obs, bus.state} !== {7'b1111001, ST_UP_RGB}) begin
         n_fail++;
         $display("FAIL mid_reset_pre: outs=%b state=%0d, expected outs=1111001 state=4", obs, bus.state);
      end
      rst = 1'b1;
      step();
      n_checks++;
      if ({obs, bus.state} !== {7'b0000000, ST_OFF}) begin
         n_fail++;
         $display("FAIL mid_reset: outs=%b state=%0d, expected outs=0000000 state=0", obs, bus.state);
      end
      rst = 1'b0;
      step();
      test_power_up();
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      test_reset();
      test_power_up();
      test_start_in_on();
      test_power_down(1'b0);
      test_simultaneous();
      test_abort();
      test_power_up();
      test_power_down(1'b1);
      test_mid_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
